// File: rtl/ws2812_pkg.sv
// Shared constants, FSM state type and pixel reorder helper for the WS2812 pixel path.
package ws2812_pkg;

  localparam int BITS_PER_LED    = 24;
  localparam int G_LSB           = 16;
  localparam int R_LSB           = 8;
  localparam int B_LSB           = 0;
  localparam int DRV_ACK_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } fb_state_t;

  // Input pixels arrive as R=[23:16], G=[15:8], B=[7:0]; the wire wants GRB.
  function automatic logic [BITS_PER_LED-1:0] rgb_to_grb(input logic [BITS_PER_LED-1:0] rgb);
    logic [BITS_PER_LED-1:0] grb;
    grb                = '0;
    grb[G_LSB +: 8]    = rgb[15:8];
    grb[R_LSB +: 8]    = rgb[23:16];
    grb[B_LSB +: 8]    = rgb[7:0];
    return grb;
  endfunction

endpackage

// File: rtl/ws2812_frame_buffer_if.sv
// Pixel write port, commit request and driver handshake of the WS2812 frame buffer.
interface ws2812_frame_buffer_if
  import ws2812_pkg::*;
#(
  parameter int LED_COUNT = 8,
  parameter int ADDR_W    = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
);

  logic                              wr_en;
  logic [ADDR_W-1:0]                 wr_addr;
  logic [BITS_PER_LED-1:0]           wr_rgb;
  logic                              commit;
  logic                              drv_busy;
  logic                              drv_start;
  logic [LED_COUNT*BITS_PER_LED-1:0] drv_data;
  logic                              commit_pending;
  logic                              frame_overrun;
  logic [15:0]                       frame_count;

  modport master (
    output wr_en, wr_addr, wr_rgb, commit, drv_busy,
    input  drv_start, drv_data, commit_pending, frame_overrun, frame_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_rgb, commit, drv_busy,
    output drv_start, drv_data, commit_pending, frame_overrun, frame_count
  );

endinterface

// File: rtl/ws2812_frame_timer.sv
// Free-running frame period counter; tick is high in the last cycle of each period.
module ws2812_frame_timer #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [TW-1:0] r_timer;
  logic          w_last;

  assign w_last = (r_timer == TW'(FRAME_CYCLES - 1));
  assign tick   = w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_last) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered WS2812 pixel store: RGB back buffer, GRB front buffer published
// on frame ticks, and a start scheduler that never restarts a busy driver.
module ws2812_frame_buffer
  import ws2812_pkg::*;
#(
  parameter int LED_COUNT    = 8,
  parameter int FRAME_CYCLES = 833333,
  parameter int ADDR_W       = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ws2812_frame_buffer_if.slave  bus
);

  localparam int ACK_W = (DRV_ACK_TIMEOUT > 1) ? $clog2(DRV_ACK_TIMEOUT) : 1;

  fb_state_t          r_state;
  logic               r_missed;
  logic               r_commit_pending;
  logic               r_drv_start;
  logic               r_frame_overrun;
  logic [15:0]        r_frame_count;
  logic [ACK_W-1:0]   r_ack_cnt;

  logic               w_tick;
  logic               w_frame_req;
  logic               w_service;
  logic               w_publish;

  ws2812_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_frame_req = w_tick | r_missed;
  assign w_service   = (r_state == IDLE) && w_frame_req && !bus.drv_busy;
  assign w_publish   = w_service && r_commit_pending;

  // Back/front register pair per LED; the front copy only moves on a publish edge.
  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_led
    logic [BITS_PER_LED-1:0] r_back;
    logic [BITS_PER_LED-1:0] r_front;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_back <= '0;
      end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(gi))) begin
        r_back <= bus.wr_rgb;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_front <= '0;
      end else if (w_publish) begin
        r_front <= rgb_to_grb(r_back);
      end
    end

    assign bus.drv_data[gi*BITS_PER_LED +: BITS_PER_LED] = r_front;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_missed         <= 1'b0;
      r_commit_pending <= 1'b0;
      r_drv_start      <= 1'b0;
      r_frame_overrun  <= 1'b0;
      r_frame_count    <= '0;
      r_ack_cnt        <= '0;
    end else begin
      r_drv_start     <= 1'b0;
      r_frame_overrun <= 1'b0;

      // A commit arriving on the publish edge survives for the next frame.
      if (bus.commit) begin
        r_commit_pending <= 1'b1;
      end else if (w_publish) begin
        r_commit_pending <= 1'b0;
      end

      if (w_tick && (r_state != IDLE)) begin
        r_frame_overrun <= 1'b1;
        r_missed        <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_service) begin
            r_drv_start   <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_missed      <= 1'b0;
            r_ack_cnt     <= '0;
            r_state       <= WAIT_BUSY;
          end else if (w_frame_req) begin
            r_missed <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (bus.drv_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_ack_cnt == ACK_W'(DRV_ACK_TIMEOUT - 1)) begin
            r_state <= IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + ACK_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.drv_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.drv_start      = r_drv_start;
  assign bus.commit_pending = r_commit_pending;
  assign bus.frame_overrun  = r_frame_overrun;
  assign bus.frame_count    = r_frame_count;

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Directed bench for ws2812_frame_buffer: LED_COUNT=6, FRAME_CYCLES=16, hand-computed GRB values.
module tb_ws2812_frame_buffer;

  localparam int LEDS = 6;
  localparam int FC   = 16;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic bmode     = 1'b0;
  logic busy_man  = 1'b0;
  logic busy_auto = 1'b0;
  int   blen      = 20;
  int   bcnt      = 0;
  int   exp_fc    = 0;

  ws2812_frame_buffer_if #(.LED_COUNT(LEDS)) bus ();

  ws2812_frame_buffer #(
    .LED_COUNT    (LEDS),
    .FRAME_CYCLES (FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.drv_busy = bmode ? busy_auto : busy_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver model: busy for blen cycles after each start pulse.
  always @(negedge clk) begin
    if (bmode) begin
      if (bus.drv_start) bcnt = blen;
      else if (bcnt > 0) bcnt = bcnt - 1;
      busy_auto = (bcnt > 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %-20s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("  ok %-20s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [23:0] led(input int i);
    return bus.drv_data[i*24 +: 24];
  endfunction

  task automatic wait_start(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.drv_start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic write(input int a, input logic [23:0] v, input logic c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[2:0];
    bus.wr_rgb  = v;
    bus.commit  = c;
    step();
    bus.wr_en   = 1'b0;
    bus.commit  = 1'b0;
  endtask

  task automatic check_fc();
    exp_fc++;
    check("frame_count", bus.frame_count, exp_fc);
  endtask

  initial begin
    int n;
    int starts;
    int ovr;
    int first;

    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_rgb  = '0;
    bus.commit  = 1'b0;
    #3 reset = 1'b0;
    step();
    check("rst_start", bus.drv_start, 0);
    check("rst_data", |bus.drv_data, 0);
    check("rst_fcount", bus.frame_count, 0);
    check("rst_pending", bus.commit_pending, 0);
    check("rst_overrun", bus.frame_overrun, 0);
    step();
    reset = 1'b1;
    bmode = 1'b1;

    // Write red to LED 3, commit, first publish.
    write(3, 24'hFF0000, 1'b0);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    check("commit_pending_set", bus.commit_pending, 1);
    wait_start(30, n);
    check("first_start_cycle", n + 2, FC);
    check("led3_grb", led(3), 24'h00FF00);
    check("led0_zero", led(0), 24'h000000);
    check("pending_cleared", bus.commit_pending, 0);
    check_fc();
    step();
    check("start_one_cycle", bus.drv_start, 0);

    // Stability: LED 0 written while busy, no commit.
    write(0, 24'h123456, 1'b0);
    blen = 5;
    wait_start(40, n);
    check("refresh2_delay", n, 20);
    check("refresh2_led0", led(0), 24'h000000);
    check("refresh2_led3", led(3), 24'h00FF00);
    check_fc();
    wait_start(40, n);
    check("refresh3_delay", n, 10);
    check("refresh3_led0", led(0), 24'h000000);
    check_fc();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    wait_start(40, n);
    check("refresh4_delay", n, 15);
    check("refresh4_led0", led(0), 24'h341256);
    check("refresh4_pending", bus.commit_pending, 0);
    check_fc();
    bmode = 1'b0;

    // Overrun: busy held 40 cycles from a start.
    wait_start(40, n);
    check("ovr_start_delay", n, 16);
    check_fc();
    busy_man = 1'b1;
    starts = 0;
    ovr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      starts += int'(bus.drv_start);
      ovr    += int'(bus.frame_overrun);
    end
    check("ovr_pulses", ovr, 2);
    check("ovr_no_start", starts, 0);
    busy_man = 1'b0;
    starts = 0;
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.drv_start) begin
        starts++;
        if (first < 0) first = i;
      end
    end
    check("ovr_one_start", starts, 1);
    check("ovr_start_after_busy", first, 2);
    check_fc();

    // Commit on the tick cycle while a commit is already pending.
    wait_start(40, n);
    check_fc();
    write(4, 24'h0000FF, 1'b1);
    repeat (14) step();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_rgb  = 24'hABCDEF;
    bus.commit  = 1'b1;
    step();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    check("simul_start", bus.drv_start, 1);
    check("simul_led4", led(4), 24'h0000FF);
    check("simul_led1_old", led(1), 24'h000000);
    check("simul_pending_kept", bus.commit_pending, 1);
    check_fc();
    wait_start(40, n);
    check("simul_next_delay", n, 16);
    check("simul_led1_new", led(1), 24'hCDABEF);
    check("simul_pending_clr", bus.commit_pending, 0);
    check_fc();

    // Busy rises on the last cycle of the ack window: driver is tracked.
    repeat (3) step();
    busy_man = 1'b1;
    starts = 0;
    ovr = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      starts += int'(bus.drv_start);
      ovr    += int'(bus.frame_overrun);
    end
    check("ack_late_overrun", ovr, 1);
    check("ack_late_no_start", starts, 0);
    busy_man = 1'b0;
    wait_start(10, n);
    check("ack_late_restart", n, 2);
    check_fc();

    // Busy rises one cycle after the ack window: FSM already back in IDLE.
    repeat (4) step();
    busy_man = 1'b1;
    starts = 0;
    ovr = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      starts += int'(bus.drv_start);
      ovr    += int'(bus.frame_overrun);
    end
    check("timeout_no_overrun", ovr, 0);
    check("timeout_no_start", starts, 0);
    busy_man = 1'b0;
    wait_start(10, n);
    check("timeout_missed_start", n, 1);
    check_fc();

    // Out-of-range writes ignored; write with commit included.
    write(6, 24'hFFFFFF, 1'b0);
    write(7, 24'h777777, 1'b0);
    write(2, 24'h00FF00, 1'b1);
    wait_start(40, n);
    check("oor_delay", n, 12);
    check("oor_led2", led(2), 24'hFF0000);
    check("oor_led0", led(0), 24'h341256);
    check("oor_led1", led(1), 24'hCDABEF);
    check("oor_led3", led(3), 24'h00FF00);
    check("oor_led4", led(4), 24'h0000FF);
    check("oor_led5", led(5), 24'h000000);
    check_fc();

    // Reset asserted mid-frame during WAIT_DONE.
    busy_man   = 1'b1;
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step();
    step();
    check("pre_rst_pending", bus.commit_pending, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_start", bus.drv_start, 0);
    check("mid_rst_data", |bus.drv_data, 0);
    check("mid_rst_fcount", bus.frame_count, 0);
    check("mid_rst_pending", bus.commit_pending, 0);
    check("mid_rst_overrun", bus.frame_overrun, 0);
    busy_man = 1'b0;
    step();
    reset = 1'b1;
    wait_start(30, n);
    check("post_rst_first_start", n, FC);
    check("post_rst_fcount", bus.frame_count, 1);
    check("post_rst_data", |bus.drv_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_buffer.md
# ws2812_frame_buffer

- Double-buffered pixel store and refresh scheduler that sits directly upstream of the WS2812 serial driver.
- Accepts per-LED RGB writes into a back buffer from the pattern/hologram logic. On a committed frame, it copies the back buffer into a stable front buffer reordered to GRB wire order.
- Pulses the driver's start once per frame period, never while the driver reports busy. The front buffer never changes during a transmission.

## Interface
- LED_COUNT, 8, number of LEDs in the chain (≥1)
- FRAME_CYCLES, 833333, clk cycles per refresh period (60 Hz at 50 MHz; ≥16)
- ADDR_W, $clog2(LED_COUNT) (min 1), width of wr_addr
- clk  in  1  50 MHz system clock
- reset  in  1  reset; one clock, reset is asynchronous and active-low
- wr_en  in  1  write strobe for one pixel into back buffer
- wr_addr  in  ADDR_W  LED index of the write
- wr_rgb  in  24  pixel value, R=[23:16], G=[15:8], B=[7:0]
- commit  in  1  one-cycle request to publish the back buffer at next frame tick
- drv_busy  in  1  driver busy flag
- drv_start  out  1  one-cycle start pulse to driver
- drv_data  out  LED_COUNT*24  front buffer; LED i at [i*24 +: 24], GRB order (G=[23:16], R=[15:8], B=[7:0])
- commit_pending  out  1  commit accepted, not yet published
- frame_overrun  out  1  one-cycle pulse when a tick arrives while previous frame is still in flight
- frame_count  out  16  number of start pulses issued, wraps

## Operation
- Reset (reset low, async): back buffer, drv_data, frame_count, and the timer clear to 0; drv_start, commit_pending, and frame_overrun are 0; state is IDLE.
- Write: wr_en with wr_addr < LED_COUNT stores wr_rgb in back[wr_addr]. Out-of-range addresses are ignored silently. Writes are always accepted in every state.
- Frame timer: free-running 0..FRAME_CYCLES-1. tick = (timer == FRAME_CYCLES-1).
- Tick while not IDLE: frame_overrun pulses. The tick is latched into a single missed flag that does not accumulate, and it is serviced on the next IDLE cycle with drv_busy low.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: on (tick or missed) and drv_busy==0:
    - if commit_pending, drv_data <= RGB→GRB reorder of back buffer and commit_pending clears;
    - drv_start <= 1, frame_count += 1, missed clears, next state WAIT_BUSY.
  - IDLE: on (tick or missed) with drv_busy high: set missed and stay in IDLE.
  - WAIT_BUSY: drv_start <= 0. Go to WAIT_DONE when drv_busy==1. If drv_busy has not risen within 4 cycles of entry, return to IDLE (driver held in reset).
  - WAIT_DONE: go to IDLE when drv_busy==0.
- Commit: sets commit_pending.
  - Commit in the same cycle as a publish leaves commit_pending set. The publish uses the back buffer as of that edge.
  - A write in the same cycle as a commit is included in that commit.
  - A write in the same cycle as a publish is not included in that publish; it lands in the back buffer for the next one.
- With no commit pending, a tick re-sends the unchanged drv_data (periodic refresh).

## Timing
- Publish and start latency: tick at cycle T with IDLE and drv_busy low → in cycle T+1, drv_data holds new content and drv_start=1 (both registered, same edge).
- drv_start is high exactly one cycle.
- drv_data changes only on a publish edge, i.e. only when drv_busy is low and the FSM is IDLE.
- Write → back buffer: 1 cycle.
- commit → commit_pending: 1 cycle.
- frame_count updates on the same edge as drv_start rises.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package ws2812_pkg:
  - BITS_PER_LED=24;
  - GRB field offsets G_LSB=16, R_LSB=8, B_LSB=0;
  - the FSM state enum;
  - DRV_ACK_TIMEOUT=4.
- Sub-module ws2812_frame_timer (parameter FRAME_CYCLES; outputs tick) is natural and is reused by later pattern generators.

## Test plan
- Reset mid-frame: reset asserted during WAIT_DONE → all outputs 0 immediately. After release, first drv_start occurs at cycle FRAME_CYCLES.
- Write/commit/publish: write LED 3 = 24'hFF0000 (red), then commit, with FRAME_CYCLES=16 and drv_busy modelled at 1 for 20 cycles after start.
  - drv_data[3*24 +: 24] == 24'h00FF00 in the cycle drv_start is high;
  - commit_pending is 0 afterwards;
  - frame_count is 1.
- Stability: write LED 0 while the driver is busy, without commit → drv_data unchanged through two subsequent refreshes. The third refresh, after commit, shows the new value.
- Overrun: FRAME_CYCLES=16, drv_busy held high 40 cycles → frame_overrun pulses at each tick. Exactly one drv_start is issued one cycle after drv_busy falls.
- Simultaneous commit and publish: commit asserted on the tick cycle → publish occurs and commit_pending remains 1. The next tick publishes again.
- Out-of-range and timeout: wr_addr=LED_COUNT → no change. drv_busy never rises → FSM returns to IDLE 4 cycles after the start, and the next tick issues a new start.
